uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//  Receive-side serial deframer for the APB UART. Synchronises the RX pin and detects start bits
//  using a 16x baud tick from the baud generator. Shifts in LSB-first data and checks the stop bit.
//  Hands each good byte to the RX FIFO write port as a one-cycle pulse, and reports frame-error,
//  break and overrun events as status pulses.
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame (5..8), LSB first, no parity, 1 stop bit
//  OVERSAMPLE   16  baud_tick_x16 pulses per bit time (even, >=4)
//  SYNC_STAGES  2   flops in RX input synchroniser (>=2)
// PORTS
//  PCLK           in   1           system clock, all logic rising-edge
//  PRESET         in   1           asynchronous, active-high reset
//  rx_en          in   1           receiver enable (CONTROL.RX_EN)
//  baud_tick_x16  in   1           1-PCLK pulse at OVERSAMPLE x baud rate
//  RX             in   1           serial input pin, idle high, asynchronous to PCLK
//  rx_fifo_full   in   1           RX FIFO full flag
//  rx_data        out  DATA_WIDTH  received byte, valid with rx_valid, held until next rx_valid
//  rx_valid       out  1           1-cycle pulse = RX FIFO wr_en
//  rx_frame_err   out  1           1-cycle pulse: stop bit sampled low, data non-zero
//  rx_break       out  1           1-cycle pulse: stop bit low and all data bits zero
//  rx_overrun     out  1           1-cycle pulse: good frame dropped because FIFO full
//  rx_busy        out  1           high whenever state != IDLE
// BEHAVIOUR
//  - Reset: synchroniser flops = 1, state = IDLE, counters = 0, rx_data = 0, all pulse outputs = 0,
//    rx_busy = 0. Reset mid-frame discards the partial frame and emits no pulse.
//  - rxs = RX after SYNC_STAGES flops. rxs is sampled only on cycles with baud_tick_x16 = 1.
//    scnt is a log2(OVERSAMPLE)-bit sample counter. bidx is the bit index.
//  - IDLE: on a tick with rx_en = 1 and rxs = 0: go to START, scnt = 0.
//  - START: each tick scnt++. On the tick where scnt == OVERSAMPLE/2-1 (mid start bit):
//    rxs = 1 means a glitch, return to IDLE with no pulse. rxs = 0 means go to DATA, scnt = 0, bidx = 0.
//  - DATA: each tick scnt++. On the tick where scnt == OVERSAMPLE-1 (mid bit): shift = {rxs, shift[W-1:1]},
//    scnt = 0, bidx++. After bit DATA_WIDTH-1 is sampled, go to STOP.
//  - STOP: on the mid-bit tick (scnt == OVERSAMPLE-1), act on rxs:
//      rxs = 1, rx_fifo_full = 0: rx_data <= shift, rx_valid = 1, go to IDLE.
//      rxs = 1, rx_fifo_full = 1: rx_overrun = 1, rx_data unchanged, go to IDLE.
//      rxs = 0, shift == 0: rx_break = 1, go to WAIT_HIGH.
//      rxs = 0, shift != 0: rx_frame_err = 1, go to WAIT_HIGH.
//  - WAIT_HIGH: on any tick with rxs = 1, go to IDLE. A held-low line yields exactly one break pulse.
//  - All outputs are registered. Each pulse is high for the single PCLK cycle after the deciding
//    tick edge. At most one pulse fires per frame, so pulses are mutually exclusive.
//  - rx_fifo_full is sampled on the same cycle as the stop-bit tick.
//  - rx_en = 0 in any state: go to IDLE on the next PCLK edge with no pulse (this aborts any
//    partial frame). Frame reception resumes only from a fresh start edge after rx_en = 1.
//  - Cycles with baud_tick_x16 = 0 change no state. Back-to-back frames are supported: IDLE is
//    re-entered at mid stop bit, so the next start edge is caught.
//  - Latency: rx_valid fires (DATA_WIDTH+1)*OVERSAMPLE + OVERSAMPLE/2 ticks after the start
//    falling edge is seen at rxs, plus 1 PCLK.
// TESTING
//  (Bench: tick every 4 PCLK, one bit = 16 ticks, RX driven 8N1.)
//  1. Send 0x55, then 0xA3 back-to-back -> two rx_valid pulses, rx_data = 0x55 then 0xA3, no error pulses.
//  2. Drive RX low for 5 ticks, then high -> no pulse of any kind; rx_busy returns to 0 at tick 8.
//  3. Send 0x3C with the stop bit forced low -> one rx_frame_err pulse, no rx_valid, rx_data unchanged.
//  4. Hold RX low for 30 bit times, then release -> exactly one rx_break pulse; FSM stays in
//     WAIT_HIGH until release; the next frame 0x81 is received correctly.
//  5. Hold rx_fifo_full = 1 and send 0xF0 -> one rx_overrun pulse, no rx_valid; with full = 0,
//     send 0x0F -> rx_valid with rx_data = 0x0F.
//  6. Mid-frame: drop rx_en at bit 3, and separately assert PRESET at bit 5 -> rx_busy = 0
//     (next cycle / immediately), no pulses; the following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises RX, finds start bits on the x16 tick, shifts data in
// LSB first, checks the stop bit and reports data, frame-error, break and overrun pulses.
`timescale 1ns/1ps
module uart_rx_deframer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  rx_en,
  input  logic                  baud_tick_x16,
  input  logic                  RX,
  input  logic                  rx_fifo_full,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_frame_err,
  output logic                  rx_break,
  output logic                  rx_overrun,
  output logic                  rx_busy
);

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_FULL = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rxs;
  logic [SCNT_W-1:0]       scnt, scnt_nxt;
  logic [BIDX_W-1:0]       bidx, bidx_nxt;
  logic [DATA_WIDTH-1:0]   shift, shift_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    valid_nxt, ferr_nxt, brk_nxt, ovr_nxt, busy_nxt;

  // Metastability synchroniser; resets to the idle-high line level
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state        <= S_IDLE;
      scnt         <= '0;
      bidx         <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_break     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state        <= state_nxt;
      scnt         <= scnt_nxt;
      bidx         <= bidx_nxt;
      shift        <= shift_nxt;
      rx_data      <= data_nxt;
      rx_valid     <= valid_nxt;
      rx_frame_err <= ferr_nxt;
      rx_break     <= brk_nxt;
      rx_overrun   <= ovr_nxt;
      rx_busy      <= busy_nxt;
    end
  end

  // Next-state and registered-output decode; nothing advances without a tick
  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    bidx_nxt  = bidx;
    shift_nxt = shift;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    brk_nxt   = 1'b0;
    ovr_nxt   = 1'b0;

    if (!rx_en) begin
      state_nxt = S_IDLE;
      scnt_nxt  = '0;
      bidx_nxt  = '0;
    end else if (baud_tick_x16) begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state_nxt = S_START;
            scnt_nxt  = '0;
          end
        end
        S_START: begin
          if (scnt == SCNT_HALF) begin
            scnt_nxt  = '0;
            bidx_nxt  = '0;
            state_nxt = rxs ? S_IDLE : S_DATA;
          end else begin
            scnt_nxt = SCNT_W'(scnt + 1'b1);
          end
        end
        S_DATA: begin
          if (scnt == SCNT_FULL) begin
            shift_nxt = {rxs, shift[DATA_WIDTH-1:1]};
            scnt_nxt  = '0;
            bidx_nxt  = BIDX_W'(bidx + 1'b1);
            if (bidx == BIDX_LAST) state_nxt = S_STOP;
          end else begin
            scnt_nxt = SCNT_W'(scnt + 1'b1);
          end
        end
        S_STOP: begin
          if (scnt == SCNT_FULL) begin
            scnt_nxt = '0;
            if (rxs) begin
              state_nxt = S_IDLE;
              if (rx_fifo_full) begin
                ovr_nxt = 1'b1;
              end else begin
                valid_nxt = 1'b1;
                data_nxt  = shift;
              end
            end else begin
              state_nxt = S_WAIT_HIGH;
              if (shift == '0) brk_nxt  = 1'b1;
              else             ferr_nxt = 1'b1;
            end
          end else begin
            scnt_nxt = SCNT_W'(scnt + 1'b1);
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised scoreboard bench for uart_rx_deframer: stimulus pushes expected events,
// a monitor pops them whenever the DUT fires a pulse.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  localparam int BIT_CLKS = 64;
  localparam int K_VALID = 0, K_FERR = 1, K_BRK = 2, K_OVR = 3;

  logic       clk = 1'b0, rst = 1'b1, rx_en = 1'b0, tick = 1'b0, rx = 1'b1, full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_break, rx_overrun, rx_busy;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         total = 0, bad = 0;
  logic [7:0] model_data = 8'h00;

  uart_rx_deframer dut (
    .PCLK(clk), .PRESET(rst), .rx_en(rx_en), .baud_tick_x16(tick), .RX(rx),
    .rx_fifo_full(full), .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: outcome of one frame from its byte, stop level and FIFO state
  task automatic expect_frame(input logic [7:0] d, input logic stop_bit);
    exp_t e;
    if (stop_bit && !full) begin
      model_data = d;
      e.kind = K_VALID;
    end else if (stop_bit) e.kind = K_OVR;
    else if (d == 8'h00)   e.kind = K_BRK;
    else                   e.kind = K_FERR;
    e.data = model_data;
    q.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int idle_bits);
    expect_frame(d, stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
    repeat (idle_bits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pending", q.size(), 0);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rx_valid || rx_frame_err || rx_break || rx_overrun) begin
      int   kind;
      exp_t e;
      check("pulse_onehot", $countones({rx_valid, rx_frame_err, rx_break, rx_overrun}), 1);
      kind = rx_valid ? K_VALID : rx_frame_err ? K_FERR : rx_break ? K_BRK : K_OVR;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse actual=kind%0d required=none", kind);
      end else begin
        e = q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("rx_data", rx_data, e.data);
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       sb;
    repeat (3) @(negedge clk);
    check("rst_busy", rx_busy, 0);
    check("rst_data", rx_data, 0);
    check("rst_pulses", {rx_valid, rx_frame_err, rx_break, rx_overrun}, 0);
    rst = 1'b0;
    rx_en = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // Back-to-back good frames
    send_frame(8'h55, 1'b1, 0);
    send_frame(8'hA3, 1'b1, 1);
    drain();

    // Start-bit glitch of 5 ticks
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_during", rx_busy, 1);
    repeat (40) @(negedge clk);
    check("glitch_busy_after", rx_busy, 0);
    repeat (BIT_CLKS) @(negedge clk);

    // Stop bit low with non-zero data
    send_frame(8'h3C, 1'b0, 1);
    drain();
    check("ferr_data_held", rx_data, model_data);

    // Long break: one pulse, then wait for line release
    expect_frame(8'h00, 1'b0);
    rx = 1'b0;
    repeat (30 * BIT_CLKS) @(negedge clk);
    check("break_seen", q.size(), 0);
    check("break_busy_held", rx_busy, 1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("break_busy_released", rx_busy, 0);
    send_frame(8'h81, 1'b1, 1);
    drain();

    // Overrun, then a good frame
    full = 1'b1;
    send_frame(8'hF0, 1'b1, 1);
    drain();
    full = 1'b0;
    send_frame(8'h0F, 1'b1, 1);
    drain();

    // rx_en dropped at bit 3
    d = 8'hC6;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("en_busy_before", rx_busy, 1);
    rx_en = 1'b0;
    @(posedge clk);
    #1;
    check("en_busy_after", rx_busy, 0);
    @(negedge clk);
    repeat (BIT_CLKS / 2 - 1) @(negedge clk);
    for (int i = 4; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    rx_en = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("en_busy_idle", rx_busy, 0);

    // Reset at bit 5
    d = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(d[i]);
    rx = d[5];
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("rst_mid_busy_before", rx_busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", rx_busy, 0);
    check("rst_mid_data", rx_data, 0);
    model_data = 8'h00;
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int i = 6; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1);
    drain();

    // Randomised frames
    for (int n = 0; n < 20; n++) begin
      d    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      sb   = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 4) == 0);
      send_frame(d, sb, sb ? $urandom_range(0, 2) : 1 + $urandom_range(0, 1));
    end
    full = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
